// File: rtl/irq_priority_arbiter_pkg.sv
// Shared constants, FSM state type and the ack-clear decoder for the IRQ arbiter.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  // One-hot vector with only bit idx set, used to clear the serviced pending bit.
  function automatic logic [N_REQ-1:0] onehot_dec(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = {N_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// 8-to-3 priority encoder: highest set bit wins, all-zero input encodes as 0.
module priority_encoder
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx
);

  // Purely combinational highest-index-wins encode.
  always_comb begin
    idx = 3'd0;
    casez (req)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_priority_arbiter.sv
// Edge-capturing interrupt front-end: pending/overrun tracking, masking,
// priority arbitration and a valid/ack presentation of the winning index.
module irq_priority_arbiter
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  input  logic             irq_ack,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overrun,
  input  logic             ovr_clr
);

  logic [N_REQ-1:0] req_q_r;
  logic [N_REQ-1:0] pending_r;
  logic [N_REQ-1:0] overrun_r;
  logic             irq_valid_r;
  logic [IDX_W-1:0] irq_id_r;
  arb_state_t       state_r;

  logic [N_REQ-1:0] edge_s;
  logic             ack_fire_s;
  logic [N_REQ-1:0] ack_clr_s;
  logic [N_REQ-1:0] ovr_set_s;
  logic [N_REQ-1:0] cand_s;
  logic [IDX_W-1:0] enc_idx_s;

  // Rising-edge detect and the clear vector for the line being acknowledged.
  always_comb begin
    edge_s     = req_in & ~req_q_r;
    ack_fire_s = irq_valid_r & irq_ack;
    ack_clr_s  = {N_REQ{1'b0}};
    if (ack_fire_s) begin
      ack_clr_s = onehot_dec(irq_id_r);
    end else begin
      ack_clr_s = {N_REQ{1'b0}};
    end
    // A new edge on an already pending line is lost unless that line is being cleared now.
    ovr_set_s = edge_s & pending_r & ~ack_clr_s;
    cand_s    = pending_r & ~mask;
  end

  priority_encoder u_enc (
    .req (cand_s),
    .idx (enc_idx_s)
  );

  // Request history register feeding the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_r <= {N_REQ{1'b0}};
    end else begin
      req_q_r <= req_in;
    end
  end

  // Pending bits: a new edge takes precedence over the ack clear so no event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N_REQ{1'b0}};
    end else begin
      pending_r <= (pending_r & ~ack_clr_s) | edge_s;
    end
  end

  // Sticky overrun flags; a set in the same cycle as ovr_clr survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= {N_REQ{1'b0}};
    end else if (ovr_clr) begin
      overrun_r <= ovr_set_s;
    end else begin
      overrun_r <= overrun_r | ovr_set_s;
    end
  end

  // Presentation FSM: latch the winner on entry to PRESENT and hold it until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      irq_valid_r <= 1'b0;
      irq_id_r    <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cand_s != {N_REQ{1'b0}}) begin
            irq_id_r    <= enc_idx_s;
            irq_valid_r <= 1'b1;
            state_r     <= PRESENT;
          end else begin
            irq_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            irq_valid_r <= 1'b1;
            state_r     <= PRESENT;
          end
        end
        default: begin
          irq_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = irq_valid_r;
  assign irq_id    = irq_id_r;
  assign pending   = pending_r;
  assign overrun   = overrun_r;

endmodule
